// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the RV32 instruction fetch front-end.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT, FULL)
//   NOP_INSTR     : instruction presented when the buffer is empty (addi x0,x0,0)
//   PC_STEP       : sequential PC increment in bytes
//   pc_advance()  : next sequential PC, wrapping modulo 2^32
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Plain 32-bit add: the carry out is dropped, so 0xFFFF_FFFC + 4 wraps to 0.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front-end of the pipelined RV32 core. Generates the fetch
// PC, runs a single-outstanding request/response handshake with instruction
// memory and buffers one fetched instruction for the IF pipeline register.
// Redirects from later stages retarget the PC; a response belonging to a
// squashed fetch is discarded.
//
// Parameters
//   RESET_PC         first fetch address after reset
//
// Ports
//   Clock            single clock, rising edge
//   Reset            asynchronous, active-high reset
//   hold             IF stalled: the buffered instruction is not consumed
//   redirect_valid   redirect fetch to redirect_pc (comes with the IF flush)
//   redirect_pc      redirect target, passed through unmodified
//   imem_req_valid   fetch request to instruction memory
//   imem_req_addr    request address
//   imem_req_ready   memory accepts the request
//   imem_rsp_valid   response data valid
//   imem_rsp_data    fetched instruction
//   fetch_pc         PC of the buffered instruction (0 when empty)
//   fetch_instr      buffered instruction (NOP when empty)
//   fetch_valid      buffer holds a valid instruction
//   perf_fetch_stall cycles spent in REQ/WAIT with an empty buffer
//                    (only when FETCH_PERF_CNT_EN is defined)
//
// Configuration macro: FETCH_PERF_CNT_EN adds the perf_fetch_stall counter.
// ----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_stall
`endif
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0] next_pc;
  logic [31:0] next_pc_nxt;
  logic        stale;
  logic        stale_nxt;
  logic        valid_nxt;
  logic [31:0] req_addr;
  logic [31:0] req_addr_nxt;
  logic        capture;
  logic        consume;

  logic [31:0] buf_pc;
  logic [31:0] buf_instr;

  assign consume = fetch_valid && !hold;

  // --------------------------------------------------------------------------
  // Control state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      next_pc     <= RESET_PC;
      stale       <= 1'b0;
      fetch_valid <= 1'b0;
      req_addr    <= RESET_PC;
    end else begin
      state       <= state_nxt;
      next_pc     <= next_pc_nxt;
      stale       <= stale_nxt;
      fetch_valid <= valid_nxt;
      req_addr    <= req_addr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    next_pc_nxt = next_pc;
    stale_nxt   = stale;
    valid_nxt   = fetch_valid;
    capture     = 1'b0;

    case (state)
      IDLE: begin
        // A redirect here only retargets the PC; fetching starts once it drops.
        if (redirect_valid) begin
          next_pc_nxt = redirect_pc;
        end else begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        // The request in flight cannot be withdrawn, so a redirect only marks
        // its eventual response as stale. A redirect accepted in the same
        // cycle as ready still leaves that response to be dropped.
        if (redirect_valid) begin
          next_pc_nxt = redirect_pc;
          stale_nxt   = 1'b1;
        end
        if (imem_req_ready) begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          // Every response ends the outstanding request, so stale clears here
          // whether the data is kept or not.
          state_nxt = REQ;
          stale_nxt = 1'b0;
          if (redirect_valid) begin
            next_pc_nxt = redirect_pc;
          end else if (!stale) begin
            capture     = 1'b1;
            valid_nxt   = 1'b1;
            next_pc_nxt = pc_advance(next_pc);
            state_nxt   = FULL;
          end
        end else if (redirect_valid) begin
          next_pc_nxt = redirect_pc;
          stale_nxt   = 1'b1;
        end
      end

      FULL: begin
        // Redirect wins over consumption: the buffered instruction is dropped.
        if (redirect_valid) begin
          next_pc_nxt = redirect_pc;
          valid_nxt   = 1'b0;
          state_nxt   = REQ;
        end else if (consume) begin
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The request address is frozen while a request is being presented so a
    // redirect cannot change it under the handshake; otherwise it follows the
    // PC that the next request will use.
    if (state == REQ) begin
      req_addr_nxt = req_addr;
    end else begin
      req_addr_nxt = next_pc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction buffer (data only, no reset: masked by fetch_valid)
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (capture) begin
      buf_pc    <= next_pc;
      buf_instr <= imem_rsp_data;
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = req_addr;
  assign fetch_pc       = fetch_valid ? buf_pc    : 32'h0000_0000;
  assign fetch_instr    = fetch_valid ? buf_instr : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Counts cycles the front-end is waiting on memory with nothing to offer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= 32'h0000_0000;
    end else if (((state == REQ) || (state == WAIT)) && !fetch_valid) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        hold;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_ready;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data  = 32'h0;

  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf1;
  logic [31:0] perf2;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;
  int mem_lat = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .Clock(Clock), .Reset(Reset), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_req_ready(mem_ready), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .fetch_pc(f_pc), .fetch_instr(f_instr), .fetch_valid(f_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_stall(perf1)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clock(Clock), .Reset(Reset), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(mem_ready), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .fetch_pc(w_pc), .fetch_instr(w_instr), .fetch_valid(w_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_stall(perf2)
`endif
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory contents: distinct word per address, 0xAAAA0001 at 0x100.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hAAAA_0001 ^ ((a - 32'h0000_0100) << 8);
  endfunction

  // Instruction memory: one response per accepted request, mem_lat cycles later.
  task automatic mem_proc();
    forever begin
      @(negedge Clock);
      if (Reset) begin
        mq_addr.delete();
        mq_due.delete();
        rsp_valid = 1'b0;
      end else begin
        rsp_valid = 1'b0;
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_data(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (req_valid && mem_ready) begin
          mq_addr.push_back(req_addr);
          mq_due.push_back(cyc + mem_lat);
        end
      end
    end
  endtask

  task automatic assert_reset();
    Reset = 1'b1;
    hold = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    mem_ready = 1'b1;
    mem_lat = 1;
    repeat (2) @(negedge Clock);
  endtask

  task automatic release_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    base = cyc;
  endtask

  // Advance to the sampling point (falling edge) of cycle k after reset release.
  task automatic at_cycle(input int k);
    do @(negedge Clock); while (cyc - base + 1 < k);
  endtask

  task automatic test_reset();
    assert_reset();
    tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", f_valid); end
    tests++; if (f_instr !== 32'h13) begin fails++; $display("FAIL reset_instr: got %h want 00000013", f_instr); end
    tests++; if (f_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", f_pc); end
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    tests++; if (req_addr !== 32'h100) begin fails++; $display("FAIL reset_req_addr: got %h want 00000100", req_addr); end
    tests++; if (w_req_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL reset_wrap_addr: got %h want fffffffc", w_req_addr); end
    release_reset();
    at_cycle(1);
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL idle_cycle_req: got %b want 0", req_valid); end
    at_cycle(2);
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin fails++; $display("FAIL first_req: got v=%b a=%h want v=1 a=00000100", req_valid, req_addr); end
    at_cycle(3);
    tests++; if (req_valid !== 1'b0 || f_valid !== 1'b0) begin fails++; $display("FAIL wait_cycle: got req=%b fv=%b want 0 0", req_valid, f_valid); end
    at_cycle(4);
    tests++; if (f_valid !== 1'b1 || f_pc !== 32'h100 || f_instr !== 32'hAAAA_0001) begin fails++; $display("FAIL first_fetch: got v=%b pc=%h i=%h want v=1 pc=00000100 i=aaaa0001", f_valid, f_pc, f_instr); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 2; i++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * i);
      at_cycle(2 + 3 * i);
      tests++; if (req_valid !== 1'b1 || req_addr !== pc) begin fails++; $display("FAIL stream_req%0d: got v=%b a=%h want v=1 a=%h", i, req_valid, req_addr, pc); end
      tests++; if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_instr !== 32'h13) begin fails++; $display("FAIL stream_empty%0d: got v=%b pc=%h i=%h want 0 0 00000013", i, f_valid, f_pc, f_instr); end
      at_cycle(4 + 3 * i);
      tests++; if (f_valid !== 1'b1 || f_pc !== pc || f_instr !== mem_data(pc)) begin fails++; $display("FAIL stream_buf%0d: got v=%b pc=%h i=%h want 1 %h %h", i, f_valid, f_pc, f_instr, pc, mem_data(pc)); end
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    for (int c = 11; c <= 15; c++) begin
      at_cycle(c);
      tests++; if (f_valid !== 1'b1 || f_pc !== 32'h108 || f_instr !== mem_data(32'h108) || req_valid !== 1'b0) begin
        fails++; $display("FAIL hold_c%0d: got v=%b pc=%h i=%h req=%b want 1 00000108 %h 0", c, f_valid, f_pc, f_instr, req_valid, mem_data(32'h108));
      end
    end
    hold = 1'b0;
    mem_lat = 3;
    at_cycle(16);
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h10C) begin fails++; $display("FAIL hold_release_req: got v=%b a=%h want 1 0000010c", req_valid, req_addr); end
  endtask

  task automatic test_redirect_wait();
    at_cycle(17);
    tests++; if (req_valid !== 1'b0 || f_valid !== 1'b0) begin fails++; $display("FAIL rw_wait: got req=%b fv=%b want 0 0", req_valid, f_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000;
    at_cycle(18);
    redirect_valid = 1'b0;
    at_cycle(19);
    mem_lat = 1;
    at_cycle(20);
    tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL rw_stale_buffered: got fv=%b want 0", f_valid); end
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h2000) begin fails++; $display("FAIL rw_new_req: got v=%b a=%h want 1 00002000", req_valid, req_addr); end
    at_cycle(22);
    tests++; if (f_valid !== 1'b1 || f_pc !== 32'h2000 || f_instr !== mem_data(32'h2000)) begin fails++; $display("FAIL rw_fetch: got v=%b pc=%h i=%h want 1 00002000 %h", f_valid, f_pc, f_instr, mem_data(32'h2000)); end
  endtask

  task automatic test_redirect_req();
    mem_ready = 1'b0;
    at_cycle(23);
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h2004) begin fails++; $display("FAIL rr_req: got v=%b a=%h want 1 00002004", req_valid, req_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    at_cycle(24);
    redirect_valid = 1'b0;
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h2004) begin fails++; $display("FAIL rr_hold24: got v=%b a=%h want 1 00002004", req_valid, req_addr); end
    at_cycle(25);
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h2004) begin fails++; $display("FAIL rr_hold25: got v=%b a=%h want 1 00002004", req_valid, req_addr); end
    @(posedge Clock);
    #1;
    mem_ready = 1'b1;
    at_cycle(26);
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h2004) begin fails++; $display("FAIL rr_accept: got v=%b a=%h want 1 00002004", req_valid, req_addr); end
    at_cycle(28);
    tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL rr_stale_buffered: got fv=%b want 0", f_valid); end
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h3000) begin fails++; $display("FAIL rr_new_req: got v=%b a=%h want 1 00003000", req_valid, req_addr); end
    at_cycle(30);
    tests++; if (f_valid !== 1'b1 || f_pc !== 32'h3000 || f_instr !== mem_data(32'h3000)) begin fails++; $display("FAIL rr_fetch: got v=%b pc=%h i=%h want 1 00003000 %h", f_valid, f_pc, f_instr, mem_data(32'h3000)); end
  endtask

  task automatic test_pc_wrap();
    assert_reset();
    release_reset();
    at_cycle(2);
    tests++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_req1: got v=%b a=%h want 1 fffffffc", w_req_valid, w_req_addr); end
    at_cycle(4);
    tests++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_instr !== mem_data(32'h100)) begin fails++; $display("FAIL wrap_fetch: got v=%b pc=%h i=%h want 1 fffffffc %h", w_valid, w_pc, w_instr, mem_data(32'h100)); end
    at_cycle(5);
    tests++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin fails++; $display("FAIL wrap_req2: got v=%b a=%h want 1 00000000", w_req_valid, w_req_addr); end
  endtask

  // Redirect arriving in the same cycle as the WAIT response (cycle 6).
  task automatic test_redirect_with_rsp();
    at_cycle(6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000;
    at_cycle(7);
    redirect_valid = 1'b0;
    tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL rs_buffered: got fv=%b want 0", f_valid); end
    tests++; if (req_valid !== 1'b1 || req_addr !== 32'h4000) begin fails++; $display("FAIL rs_req: got v=%b a=%h want 1 00004000", req_valid, req_addr); end
    at_cycle(9);
    tests++; if (f_valid !== 1'b1 || f_pc !== 32'h4000 || f_instr !== mem_data(32'h4000)) begin fails++; $display("FAIL rs_fetch: got v=%b pc=%h i=%h want 1 00004000 %h", f_valid, f_pc, f_instr, mem_data(32'h4000)); end
  endtask

  // Random hold/ready/latency/redirect against an instruction-stream model:
  // the stream starts at RESET_PC, advances by 4 per consumed instruction and
  // restarts at the target of every redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        must_inv;
    logic        prev_stall;
    int          delivered;
    exp_pc = 32'h100;
    must_inv = 1'b0;
    prev_stall = 1'b0;
    prev_addr = 32'h0;
    delivered = 0;
    assert_reset();
    release_reset();
    for (int i = 0; i < 1500; i++) begin
      hold           = ($urandom_range(0, 99) < 30);
      mem_ready      = ($urandom_range(0, 99) < 70);
      mem_lat        = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = $urandom;
      @(negedge Clock);
      tests++;
      if (f_valid === 1'b1) begin
        if (f_pc !== exp_pc || f_instr !== mem_data(exp_pc)) begin
          fails++; $display("FAIL rnd_buf c%0d: got pc=%h i=%h want %h %h", i, f_pc, f_instr, exp_pc, mem_data(exp_pc));
        end
      end else if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_instr !== 32'h13) begin
        fails++; $display("FAIL rnd_empty c%0d: got v=%b pc=%h i=%h want 0 0 00000013", i, f_valid, f_pc, f_instr);
      end
      if (must_inv) begin
        tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL rnd_drop c%0d: got fv=%b want 0", i, f_valid); end
      end
      if (prev_stall) begin
        tests++; if (req_valid !== 1'b1 || req_addr !== prev_addr) begin fails++; $display("FAIL rnd_req_stable c%0d: got v=%b a=%h want 1 %h", i, req_valid, req_addr, prev_addr); end
      end
      must_inv = 1'b0;
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        must_inv = 1'b1;
      end else if (f_valid === 1'b1 && !hold) begin
        exp_pc = exp_pc + 32'd4;
        must_inv = 1'b1;
        delivered++;
      end
      prev_stall = req_valid && !mem_ready;
      prev_addr = req_addr;
      @(posedge Clock);
      #1;
    end
    hold = 1'b0;
    redirect_valid = 1'b0;
    mem_ready = 1'b1;
    tests++; if (delivered < 20) begin fails++; $display("FAIL rnd_progress: got %0d delivered want >= 20", delivered); end
  endtask

  initial begin
    Reset = 1'b1;
    hold = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    mem_ready = 1'b1;
    fork
      mem_proc();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none
    test_reset();
    test_streaming();
    test_hold();
    test_redirect_wait();
    test_redirect_req();
    test_pc_wrap();
    test_redirect_with_rsp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
